noc_node: RTL and testbench

//  4-port wormhole router tile of the 2-D mesh NoC; no local injection/ejection port.

---
 rtl/noc_pkg.sv | 48 ++++
 rtl/node_port.sv | 13 +
 rtl/node_in_port.sv | 78 +++++++
 rtl/noc_node.sv | 87 ++++++++
 tb/tb_noc_node.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared types for the 2-D mesh NoC: directions, flit and header layout.
// Also holds the dimension-order (Y first) route helper.
package noc_pkg;

  localparam int ADDR_W = 4;
  localparam int FLIT_W = 32;

  typedef enum logic [1:0] {
    NORTH = 2'd0,
    EAST  = 2'd1,
    SOUTH = 2'd2,
    WEST  = 2'd3
  } dir_t;

  typedef enum logic {
    HEADER = 1'b0,
    BODY   = 1'b1
  } flit_type_t;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
  } addr_t;

  typedef struct packed {
    addr_t      dst_addr;
    logic [7:0] tail_length;
  } control_hdr_t;

  typedef struct packed {
    flit_type_t        flit_type;
    logic [FLIT_W-1:0] payload;
  } flit_t;

  // Unsigned compares: out-of-mesh targets keep heading to the boundary.
  // A local target also lands on NORTH; callers filter it out first.
  function automatic dir_t xy_route(
    input addr_t             dst,
    input logic [ADDR_W-1:0] x,
    input logic [ADDR_W-1:0] y
  );
    if (dst.y > y)      return EAST;
    else if (dst.y < y) return WEST;
    else if (dst.x > x) return SOUTH;
    else                return NORTH;
  endfunction

endpackage

// File: rtl/node_port.sv
// One direction of a mesh link: flit + enable forward, ack backward.
// rx: node side of an ingress link; tx: node side of an egress link.
interface node_port;
  import noc_pkg::*;

  flit_t flit;
  logic  enable;
  logic  ack;

  modport rx (input flit, input enable, output ack);
  modport tx (output flit, output enable, input ack);

endinterface

// File: rtl/node_in_port.sv
// Per-input header decode, XY route, body counter and lock/dest register.
// Ports: flit/enable from neighbour, grant/oack from the top, req/dest/locked/ack out.
module node_in_port
  import noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] X = 1,
  parameter logic [ADDR_W-1:0] Y = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t flit,
  input  logic  enable,
  input  logic  grant,
  input  logic  oack,
  output logic  req,
  output dir_t  dest,
  output logic  locked,
  output logic  ack
);

  control_hdr_t hdr;
  logic         open_q;
  logic         drop_q;
  logic [7:0]   cnt_q;
  dir_t         dest_q;
  logic         is_hdr;
  logic         here;
  logic         xfer;
  logic         unused_pl;

  assign hdr       = control_hdr_t'(flit.payload[15:0]);
  assign unused_pl = ^flit.payload[FLIT_W-1:16];
  assign is_hdr    = flit.flit_type == HEADER;
  assign here      = (hdr.dst_addr.x == X) && (hdr.dst_addr.y == Y);
  assign dest      = open_q ? dest_q
                            : xy_route(hdr.dst_addr, X, Y);
  assign locked    = open_q && !drop_q;

  // Kept apart from ack so req never depends on grant.
  assign req = !rst && enable && !open_q && is_hdr && !here;

  always_comb begin
    ack = 1'b0;
    if (!rst && enable) begin
      if (open_q)
        ack = drop_q ? 1'b1 : oack;
      else if (!is_hdr || here)
        ack = 1'b1;
      else
        ack = grant && oack;
    end
  end

  assign xfer = enable && ack;

  // A packet stays open until its last body flit; local or
  // orphaned traffic is swallowed in drop mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      dest_q <= NORTH;
    end else if (xfer) begin
      if (open_q) begin
        cnt_q <= cnt_q - 8'd1;
        if (cnt_q == 8'd1)
          open_q <= 1'b0;
      end else if (is_hdr && hdr.tail_length != 8'd0) begin
        open_q <= 1'b1;
        drop_q <= here;
        cnt_q  <= hdr.tail_length;
        dest_q <= xy_route(hdr.dst_addr, X, Y);
      end
    end
  end

endmodule

// File: rtl/noc_node.sv
// 4-port wormhole mesh router tile: XY routing, fixed-priority output
// arbitration, zero-latency crossbar. Ports: clk, rst, ports_down[4], ports_up[4].
module noc_node
  import noc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] X = 1,
  parameter logic [ADDR_W-1:0] Y = 1
) (
  input logic  clk,
  input logic  rst,
  node_port.rx ports_down [4],
  node_port.tx ports_up   [4]
);

  flit_t      in_flit  [4];
  logic [3:0] in_en;
  dir_t       dest     [4];
  logic [3:0] req;
  logic [3:0] locked;
  logic [3:0] grant;
  logic [3:0] bp_data_i;
  logic [3:0] bp_data_o;
  logic [3:0] own_vld;
  logic [1:0] own      [4];
  flit_t      out_flit [4];
  logic [3:0] out_en;

  for (genvar d = 0; d < 4; d++) begin : g_port
    assign in_flit[d]         = ports_down[d].flit;
    assign in_en[d]           = ports_down[d].enable;
    assign ports_down[d].ack  = bp_data_o[d];
    assign bp_data_i[d]       = ports_up[d].ack;
    assign ports_up[d].flit   = out_flit[d];
    assign ports_up[d].enable = out_en[d];

    node_in_port #(.X(X), .Y(Y)) u_in (
      .clk    (clk),
      .rst    (rst),
      .flit   (in_flit[d]),
      .enable (in_en[d]),
      .grant  (grant[d]),
      .oack   (bp_data_i[dest[d]]),
      .req    (req[d]),
      .dest   (dest[d]),
      .locked (locked[d]),
      .ack    (bp_data_o[d])
    );
  end

  // A held lock wins; otherwise the lowest-index requester
  // (NORTH first) takes an idle output.
  always_comb begin
    own_vld = '0;
    for (int o = 0; o < 4; o++) begin
      own[o] = '0;
      for (int i = 3; i >= 0; i--) begin
        if (req[i] && 2'(dest[i]) == 2'(o)) begin
          own_vld[o] = 1'b1;
          own[o]     = 2'(i);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (locked[i] && 2'(dest[i]) == 2'(o)) begin
          own_vld[o] = 1'b1;
          own[o]     = 2'(i);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      grant[i] = own_vld[dest[i]] && own[dest[i]] == 2'(i);
  end

  always_comb begin
    for (int o = 0; o < 4; o++) begin
      out_flit[o] = '0;
      out_en[o]   = 1'b0;
      if (own_vld[o]) begin
        out_flit[o] = in_flit[own[o]];
        out_en[o]   = in_en[own[o]];
      end
    end
  end

endmodule

// File: tb/tb_noc_node.sv
// Bench for noc_node: directed scenarios then random traffic,
// all compared against a packet-level reference model.
module tb_noc_node;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flit_t      d_flit [4];
  logic [3:0] d_en;
  logic [3:0] u_ack;
  flit_t      o_flit [4];
  logic [3:0] o_en;
  logic [3:0] o_ack;

  node_port pd [4] ();
  node_port pu [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_c
    assign pd[g].flit   = d_flit[g];
    assign pd[g].enable = d_en[g];
    assign pu[g].ack    = u_ack[g];
    assign o_flit[g]    = pu[g].flit;
    assign o_en[g]      = pu[g].enable;
    assign o_ack[g]     = pd[g].ack;
  end

  noc_node #(.X(4'd1), .Y(4'd1)) dut (
    .clk        (clk),
    .rst        (rst),
    .ports_down (pd),
    .ports_up   (pu)
  );

  // Model: bodies still owed per input and where they go (-1 = drop).
  int         m_rem [4];
  int         m_out [4];
  logic [3:0] e_ack;
  logic [3:0] e_en;
  flit_t      e_flit [4];
  logic [3:0] xfer;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk_hdr(int x, int y, int tl);
    flit_t f;
    f.flit_type = HEADER;
    f.payload = {16'($urandom), 4'(x), 4'(y), 8'(tl)};
    return f;
  endfunction

  function automatic flit_t mk_body();
    flit_t f;
    f.flit_type = BODY;
    f.payload = $urandom;
    return f;
  endfunction

  // -1 means the packet is addressed to this tile (1,1).
  function automatic int route(int x, int y);
    if (y > 1) return 1;
    if (y < 1) return 3;
    if (x > 1) return 2;
    if (x < 1) return 0;
    return -1;
  endfunction

  function automatic int hdr_route(flit_t f);
    return route(int'(f.payload[15:12]), int'(f.payload[11:8]));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_rem[i] = 0;
      m_out[i] = -1;
    end
  endtask

  task automatic model_eval();
    int own [4];
    for (int o = 0; o < 4; o++) own[o] = -1;
    for (int i = 0; i < 4; i++)
      if (m_rem[i] > 0 && m_out[i] >= 0) own[m_out[i]] = i;
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++)
        if (own[o] < 0 && d_en[i] && m_rem[i] == 0 &&
            d_flit[i].flit_type == HEADER && hdr_route(d_flit[i]) == o)
          own[o] = i;
    for (int o = 0; o < 4; o++) begin
      e_en[o]   = own[o] >= 0 && d_en[own[o]];
      e_flit[o] = own[o] >= 0 ? d_flit[own[o]] : '0;
    end
    for (int i = 0; i < 4; i++) begin
      int r;
      e_ack[i] = 1'b0;
      r = hdr_route(d_flit[i]);
      if (!d_en[i]) e_ack[i] = 1'b0;
      else if (m_rem[i] > 0)
        e_ack[i] = m_out[i] < 0 ? 1'b1 : u_ack[m_out[i]];
      else if (d_flit[i].flit_type == BODY || r < 0) e_ack[i] = 1'b1;
      else e_ack[i] = own[r] == i && u_ack[r];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ack[%0d]", i), 64'(o_ack[i]), 64'(e_ack[i]));
      check($sformatf("en[%0d]", i), 64'(o_en[i]), 64'(e_en[i]));
      if (e_en[i])
        check($sformatf("flit[%0d]", i), 64'(o_flit[i]), 64'(e_flit[i]));
    end
    for (int i = 0; i < 4; i++) begin
      xfer[i] = d_en[i] && e_ack[i];
      if (xfer[i]) begin
        if (m_rem[i] > 0) m_rem[i]--;
        else if (d_flit[i].flit_type == HEADER &&
                 d_flit[i].payload[7:0] != 8'd0) begin
          m_rem[i] = int'(d_flit[i].payload[7:0]);
          m_out[i] = hdr_route(d_flit[i]);
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    flit_t b;
    d_en  = '0;
    u_ack = '0;
    for (int i = 0; i < 4; i++) d_flit[i] = '0;
    model_clear();
    #1;
    check("rst_en", 64'(o_en), 64'h0);
    check("rst_ack", 64'(o_ack), 64'h0);
    #9 rst = 1'b0;
    advance();

    // 1: WEST header to (1,3) leaves EAST
    d_flit[3] = mk_hdr(1, 3, 3);
    d_en[3]   = 1'b1;
    u_ack[1]  = 1'b1;
    sample();
    check("t1_dest_w", 64'(dut.dest[3]), 64'(EAST));
    check("t1_bpi_e", 64'(dut.bp_data_i[1]), 64'h1);
    check("t1_bpo_w", 64'(dut.bp_data_o[3]), 64'h1);
    check("t1_en_e", 64'(o_en[1]), 64'h1);
    advance();

    // 2: three bodies, then EAST idle
    for (int k = 0; k < 3; k++) begin
      b = mk_body();
      d_flit[3] = b;
      sample();
      check("t2_flit_e", 64'(o_flit[1]), 64'(b));
      advance();
    end
    d_en[3] = 1'b0;
    sample();
    check("t2_idle_e", 64'(o_en[1]), 64'h0);
    advance();

    // 3: backpressure holds the header
    d_flit[3] = mk_hdr(1, 3, 0);
    d_en[3]   = 1'b1;
    u_ack[1]  = 1'b0;
    sample();
    check("t3_ack_lo", 64'(o_ack[3]), 64'h0);
    advance();
    u_ack[1] = 1'b1;
    sample();
    check("t3_ack_hi", 64'(o_ack[3]), 64'h1);
    advance();
    d_en[3] = 1'b0;

    // 4: NORTH beats WEST for EAST until its tail is done
    d_flit[0] = mk_hdr(1, 3, 2);
    d_flit[3] = mk_hdr(1, 3, 0);
    d_en[0]   = 1'b1;
    d_en[3]   = 1'b1;
    sample();
    check("t4_ack_n", 64'(o_ack[0]), 64'h1);
    check("t4_ack_w", 64'(o_ack[3]), 64'h0);
    advance();
    for (int k = 0; k < 2; k++) begin
      d_flit[0] = mk_body();
      sample();
      check("t4_wait_w", 64'(o_ack[3]), 64'h0);
      advance();
    end
    d_en[0] = 1'b0;
    sample();
    check("t4_win_w", 64'(o_ack[3]), 64'h1);
    advance();
    d_en[3] = 1'b0;

    // 5: SOUTH header to (0,1) goes NORTH; local header dropped
    d_flit[2] = mk_hdr(0, 1, 0);
    d_en[2]   = 1'b1;
    u_ack[0]  = 1'b1;
    sample();
    check("t5_dest_s", 64'(dut.dest[2]), 64'(NORTH));
    check("t5_en_n", 64'(o_en[0]), 64'h1);
    advance();
    d_flit[2] = mk_hdr(1, 1, 0);
    sample();
    check("t5_loc_ack", 64'(o_ack[2]), 64'h1);
    check("t5_loc_en", 64'(o_en), 64'h0);
    advance();
    d_en[2] = 1'b0;

    // 6: reset in the middle of a packet
    d_flit[3] = mk_hdr(1, 3, 3);
    d_en[3]   = 1'b1;
    sample();
    advance();
    d_flit[3] = mk_body();
    sample();
    advance();
    d_flit[3] = mk_body();
    #2 rst = 1'b1;
    #1;
    check("t6_rst_en", 64'(o_en), 64'h0);
    check("t6_rst_ack", 64'(o_ack), 64'h0);
    model_clear();
    #10 rst = 1'b0;
    sample();
    check("t6_stray_ack", 64'(o_ack[3]), 64'h1);
    check("t6_stray_en", 64'(o_en), 64'h0);
    advance();
    d_en = '0;

    // Random traffic; senders hold a flit until it is acked.
    xfer = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(d_en[i] && !xfer[i])) begin
          d_en[i] = ($urandom % 4) != 0;
          if (m_rem[i] > 0 || ($urandom % 8) == 0)
            d_flit[i] = mk_body();
          else if (($urandom % 8) == 0)
            d_flit[i] = mk_hdr(15, $urandom % 4, $urandom % 4);
          else
            d_flit[i] = mk_hdr($urandom % 4, $urandom % 4,
                               $urandom % 4);
        end
        u_ack[i] = ($urandom % 4) != 0;
      end
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
